flit_pipe_reg: RTL

Parametrised, elastic flit pipeline register for the virtual channel router datapath. It replaces single-bit asynchronously cleared flops on inter-stage links with a DEPTH-stage, WIDTH-bit register chain. Each stage carries a valid bit and the chain supports valid/ready backpressure, bubble collapsing, a synchronous flush and an occupancy count. One instance sits on each router pipeline link, for example between input buffer and switch allocator, or switch traversal and output link.

---
 rtl/flit_pipe_reg_if.sv | 27 ++
 rtl/flit_pipe_reg.sv | 76 +++++++
 2 files changed

// File: rtl/flit_pipe_reg_if.sv
// Flit link bundle between an upstream producer and the pipeline register.
// The master drives flits, flush and downstream ready; the slave returns ready, output flit and occupancy.
interface flit_pipe_reg_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [OCC_W-1:0] occupancy;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/flit_pipe_reg.sv
// Elastic DEPTH-stage flit pipeline register with valid/ready backpressure,
// bubble collapsing, synchronous flush and a registered occupancy count.
module flit_pipe_reg #(
    parameter int               WIDTH     = 16,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic           clk,
    input  logic           clr,
    flit_pipe_reg_if.slave bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] w_v;
    logic [WIDTH-1:0] w_d [DEPTH];
    logic [DEPTH-1:0] w_ready;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [OCC_W-1:0] r_occ;

    assign bus.in_ready  = w_ready[0] && !bus.flush;
    assign w_in_xfer     = bus.in_valid && bus.in_ready;
    assign w_out_xfer    = w_v[DEPTH-1] && bus.out_ready;
    assign bus.out_valid = w_v[DEPTH-1];
    assign bus.out_data  = w_d[DEPTH-1];
    assign bus.occupancy = r_occ;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic             r_v;
        logic [WIDTH-1:0] r_d;
        logic             w_prev_v;
        logic [WIDTH-1:0] w_prev_d;

        // A stage can move whenever any stage at or after it has a bubble,
        // or the tail is draining; flattened to avoid a combinational chain.
        assign w_ready[gi] = ~(&w_v[DEPTH-1:gi]) | bus.out_ready;

        if (gi == 0) begin : g_head
            assign w_prev_v = w_in_xfer;
            assign w_prev_d = bus.in_data;
        end else begin : g_body
            assign w_prev_v = w_v[gi-1];
            assign w_prev_d = w_d[gi-1];
        end

        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                r_v <= 1'b0;
                r_d <= RESET_VAL;
            end else if (bus.flush) begin
                r_v <= 1'b0;
                r_d <= RESET_VAL;
            end else if (w_ready[gi]) begin
                r_v <= w_prev_v;
                if (w_prev_v) begin
                    r_d <= w_prev_d;
                end
            end
        end

        assign w_v[gi] = r_v;
        assign w_d[gi] = r_d;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_occ <= '0;
        end else if (bus.flush) begin
            r_occ <= '0;
        end else if (w_in_xfer && !w_out_xfer) begin
            r_occ <= r_occ + OCC_W'(1);
        end else if (w_out_xfer && !w_in_xfer) begin
            r_occ <= r_occ - OCC_W'(1);
        end
    end
endmodule
